// File: rtl/input_conditioner.sv
// Input conditioning for BTNR and SW[15:0]: two-flop synchronizers, debounce,
// press pulse/sticky/counter and an atomic switch-vector update strobe.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_raw,
  input  logic [15:0] sw_raw,
  input  logic        clr_sticky,
  output logic        btn_level,
  output logic        btn_pulse,
  output logic        btn_sticky,
  output logic [7:0]  press_count,
  output logic [15:0] sw_stable,
  output logic        sw_changed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             btn_meta_q, btn_meta_d;
  logic             btn_s_q, btn_s_d;
  logic [15:0]      sw_meta_q, sw_meta_d;
  logic [15:0]      sw_s_q, sw_s_d;
  logic [15:0]      sw_prev_q, sw_prev_d;

  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             btn_level_q, btn_level_d;
  logic             btn_pulse_q, btn_pulse_d;
  logic             btn_sticky_q, btn_sticky_d;
  logic [7:0]       press_count_q, press_count_d;

  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [15:0]      sw_stable_q, sw_stable_d;
  logic             sw_changed_q, sw_changed_d;

  always_comb begin
    btn_meta_d = btn_raw;
    btn_s_d    = btn_meta_q;
    sw_meta_d  = sw_raw;
    sw_s_d     = sw_meta_q;
    sw_prev_d  = sw_s_q;
  end

  // Button: count consecutive cycles the synchronized input disagrees with the level.
  always_comb begin
    bcnt_d      = bcnt_q;
    btn_level_d = btn_level_q;
    if (btn_s_q == btn_level_q) begin
      bcnt_d = '0;
    end else if (bcnt_q == CNT_LAST) begin
      btn_level_d = btn_s_q;
      bcnt_d      = '0;
    end else begin
      bcnt_d = bcnt_q + CNT_ONE;
    end
  end

  // Sticky set takes priority over the processor's clear so no press is lost.
  always_comb begin
    btn_pulse_d   = btn_level_d & ~btn_level_q;
    btn_sticky_d  = btn_pulse_q | (btn_sticky_q & ~clr_sticky);
    press_count_d = press_count_q + {7'd0, btn_pulse_q};
  end

  // Switches share one counter: any bit moving restarts the whole vector.
  always_comb begin
    scnt_d       = scnt_q;
    sw_stable_d  = sw_stable_q;
    sw_changed_d = 1'b0;
    if (sw_s_q != sw_prev_q) begin
      scnt_d = '0;
    end else if (sw_s_q == sw_stable_q) begin
      scnt_d = '0;
    end else if (scnt_q == CNT_LAST) begin
      sw_stable_d  = sw_s_q;
      scnt_d       = '0;
      sw_changed_d = 1'b1;
    end else begin
      scnt_d = scnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      btn_meta_q    <= 1'b0;
      btn_s_q       <= 1'b0;
      sw_meta_q     <= '0;
      sw_s_q        <= '0;
      sw_prev_q     <= '0;
      bcnt_q        <= '0;
      btn_level_q   <= 1'b0;
      btn_pulse_q   <= 1'b0;
      btn_sticky_q  <= 1'b0;
      press_count_q <= '0;
      scnt_q        <= '0;
      sw_stable_q   <= '0;
      sw_changed_q  <= 1'b0;
    end else begin
      btn_meta_q    <= btn_meta_d;
      btn_s_q       <= btn_s_d;
      sw_meta_q     <= sw_meta_d;
      sw_s_q        <= sw_s_d;
      sw_prev_q     <= sw_prev_d;
      bcnt_q        <= bcnt_d;
      btn_level_q   <= btn_level_d;
      btn_pulse_q   <= btn_pulse_d;
      btn_sticky_q  <= btn_sticky_d;
      press_count_q <= press_count_d;
      scnt_q        <= scnt_d;
      sw_stable_q   <= sw_stable_d;
      sw_changed_q  <= sw_changed_d;
    end
  end

  assign btn_level   = btn_level_q;
  assign btn_pulse   = btn_pulse_q;
  assign btn_sticky  = btn_sticky_q;
  assign press_count = press_count_q;
  assign sw_stable   = sw_stable_q;
  assign sw_changed  = sw_changed_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4: directed scenarios plus
// a random phase, all checked cycle-by-cycle against a run-length reference model.
module tb_input_conditioner;

  localparam int unsigned D = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        btn_raw = 1'b0;
  logic [15:0] sw_raw = '0;
  logic        clr_sticky = 1'b0;
  logic        btn_level, btn_pulse, btn_sticky, sw_changed;
  logic [7:0]  press_count;
  logic [15:0] sw_stable;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: synchronizer as a 2-sample delay, debounce as "last N
  // synchronized samples all equal and different from the accepted value".
  logic        mb_pipe [2];
  logic [15:0] ms_pipe [2];
  logic        bhist [$];
  logic [15:0] shist [$];
  logic        m_level, m_pulse, m_sticky, m_changed;
  logic [7:0]  m_count;
  logic [15:0] m_stable;

  input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .clr_sticky(clr_sticky), .btn_level(btn_level), .btn_pulse(btn_pulse),
    .btn_sticky(btn_sticky), .press_count(press_count), .sw_stable(sw_stable),
    .sw_changed(sw_changed)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic        bs, rose, all_flip, same;
    logic [15:0] ss;
    if (!reset) begin
      mb_pipe[0] = 1'b0; mb_pipe[1] = 1'b0;
      ms_pipe[0] = '0;   ms_pipe[1] = '0;
      bhist.delete(); shist.delete();
      m_level = 0; m_pulse = 0; m_sticky = 0; m_changed = 0;
      m_count = '0; m_stable = '0;
    end else begin
      bs = mb_pipe[0]; mb_pipe[0] = mb_pipe[1]; mb_pipe[1] = btn_raw;
      ss = ms_pipe[0]; ms_pipe[0] = ms_pipe[1]; ms_pipe[1] = sw_raw;
      bhist.push_back(bs); if (bhist.size() > D) void'(bhist.pop_front());
      shist.push_back(ss); if (shist.size() > D + 1) void'(shist.pop_front());
      m_count  = m_count + 8'(m_pulse);
      m_sticky = m_pulse | (m_sticky & ~clr_sticky);
      rose = 1'b0;
      if (bhist.size() == D) begin
        all_flip = 1'b1;
        foreach (bhist[i]) if (bhist[i] == m_level) all_flip = 1'b0;
        if (all_flip) begin
          m_level = ~m_level;
          rose = m_level;
        end
      end
      m_pulse = rose;
      m_changed = 1'b0;
      if (shist.size() == D + 1) begin
        same = 1'b1;
        foreach (shist[i]) if (shist[i] != shist[0]) same = 1'b0;
        if (same && shist[0] != m_stable) begin
          m_stable  = shist[0];
          m_changed = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("btn_level",   {31'd0, btn_level},   {31'd0, m_level});
    chk("btn_pulse",   {31'd0, btn_pulse},   {31'd0, m_pulse});
    chk("btn_sticky",  {31'd0, btn_sticky},  {31'd0, m_sticky});
    chk("press_count", {24'd0, press_count}, {24'd0, m_count});
    chk("sw_stable",   {16'd0, sw_stable},   {16'd0, m_stable});
    chk("sw_changed",  {31'd0, sw_changed},  {31'd0, m_changed});
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
    check_all();
  endtask

  task automatic press(input int hi, input int lo);
    btn_raw = 1'b1;
    repeat (hi) tick();
    btn_raw = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    int lvl_at, chg_at, pulses, chgs, guard;
    logic [7:0] c0;
    bit found;

    // 1: reset with inputs held high, then release
    reset = 1'b0; btn_raw = 1'b1; sw_raw = 16'hFFFF;
    repeat (3) tick();
    chk("t1_reset_zero", {press_count, sw_stable, btn_level, btn_pulse, btn_sticky, sw_changed}, 32'd0);
    reset = 1'b1;
    lvl_at = 0; chg_at = 0; pulses = 0; chgs = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (btn_level === 1'b1 && lvl_at == 0) lvl_at = e;
      if (btn_pulse === 1'b1) pulses++;
      if (sw_changed === 1'b1) begin
        chgs++;
        if (chg_at == 0) chg_at = e;
      end
    end
    chk("t1_level_latency", lvl_at, 6);
    chk("t1_pulse_count", pulses, 1);
    chk("t1_press_count", {24'd0, press_count}, 32'd1);
    chk("t1_sw_stable", {16'd0, sw_stable}, 32'h0000FFFF);
    chk("t1_sw_changed_count", chgs, 1);
    chk("t1_sw_latency", chg_at, 7);

    btn_raw = 1'b0;
    repeat (10) tick();

    // 2: short glitch is discarded
    c0 = m_count; pulses = 0;
    btn_raw = 1'b1;
    repeat (3) tick();
    btn_raw = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (btn_pulse === 1'b1 || btn_level === 1'b1) pulses++;
    end
    chk("t2_glitch_no_level", pulses, 0);
    chk("t2_glitch_count", {24'd0, press_count}, {24'd0, c0});

    // 3: three clean presses, then acknowledge
    c0 = m_count; pulses = 0;
    for (int p = 0; p < 3; p++) begin
      btn_raw = 1'b1;
      for (int e = 0; e < 10; e++) begin tick(); if (btn_pulse === 1'b1) pulses++; end
      btn_raw = 1'b0;
      for (int e = 0; e < 10; e++) begin tick(); if (btn_pulse === 1'b1) pulses++; end
    end
    chk("t3_pulses", pulses, 3);
    chk("t3_count", {24'd0, press_count}, {24'd0, 8'(c0 + 8'd3)});
    chk("t3_sticky_set", {31'd0, btn_sticky}, 32'd1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("t3_sticky_cleared", {31'd0, btn_sticky}, 32'd0);

    // 4: clear coincident with pulse, then wrap the counter
    btn_raw = 1'b1;
    found = 1'b0;
    for (int e = 0; e < 20 && !found; e++) begin
      tick();
      if (m_pulse) found = 1'b1;
    end
    chk("t4_pulse_seen", {31'd0, found}, 32'd1);
    chk("t4_pulse_dut", {31'd0, btn_pulse}, 32'd1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("t4_set_wins", {31'd0, btn_sticky}, 32'd1);
    btn_raw = 1'b0;
    repeat (8) tick();
    guard = 0;
    while (m_count != 8'd255 && guard < 300) begin
      press(8, 8);
      guard++;
    end
    chk("t4_preload_255", {24'd0, press_count}, 32'd255);
    press(8, 8);
    chk("t4_wrap_zero", {24'd0, press_count}, 32'd0);

    // 5: bit-3 chatter, then settle at 0x0008
    chgs = 0;
    for (int t = 0; t < 10; t++) begin
      sw_raw = (t % 2 == 0) ? 16'h0008 : 16'h0000;
      repeat (2) begin tick(); if (sw_changed === 1'b1) chgs++; end
    end
    chk("t5_no_change_during_chatter", chgs, 0);
    sw_raw = 16'h0008;
    chg_at = 0; chgs = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (sw_changed === 1'b1) begin
        chgs++;
        if (chg_at == 0) chg_at = e;
      end
    end
    chk("t5_latency", chg_at, 7);
    chk("t5_single_strobe", chgs, 1);
    chk("t5_stable", {16'd0, sw_stable}, 32'h00000008);

    // 6: reset in the middle of a button debounce
    btn_raw = 1'b1;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    chk("t6_reset_outputs", {press_count, sw_stable, btn_level, btn_pulse, btn_sticky, sw_changed}, 32'd0);
    reset = 1'b1;
    lvl_at = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (btn_level === 1'b1 && lvl_at == 0) lvl_at = e;
    end
    chk("t6_level_latency", lvl_at, 6);
    chk("t6_press_count", {24'd0, press_count}, 32'd1);
    btn_raw = 1'b0;
    repeat (8) tick();

    // Random phase: random hold lengths, occasional acknowledge and reset
    for (int i = 0; i < 250; i++) begin
      btn_raw    = 1'($urandom_range(0, 1));
      sw_raw     = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                               : sw_raw ^ (16'd1 << $urandom_range(0, 15));
      clr_sticky = ($urandom_range(0, 7) == 0);
      reset      = !($urandom_range(0, 80) == 0);
      repeat ($urandom_range(1, 9)) tick();
    end
    reset = 1'b1;
    clr_sticky = 1'b0;
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Front-end conditioning stage for the board's raw BTNR and SW[15:0] pins, placed between the top-level pins and the register file's memory-mapped input registers.
- Synchronizes each input into the 100 MHz domain and debounces it.
- Produces clean levels, a single-cycle press pulse, a sticky press flag, a wrapping press counter and a switch-change strobe.
- The processor polls these through the register file and acknowledges presses via clr_sticky.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz); legal minimum 2.
CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clock  input  1  system clock (CLK100MHZ domain)
reset  input  1  synchronous, active-low reset; 0 = reset, sampled on rising clock edge
btn_raw  input  1  asynchronous button pin (BTNR)
sw_raw  input  16  asynchronous switch pins (SW)
clr_sticky  input  1  processor acknowledge; clears btn_sticky
btn_level  output  1  debounced button level
btn_pulse  output  1  one-cycle strobe on debounced 0->1 of button
btn_sticky  output  1  latched "press occurred" flag
press_count  output  8  count of debounced presses, wraps
sw_stable  output  16  debounced switch vector
sw_changed  output  1  one-cycle strobe when sw_stable updates

Behaviour:
- All state updates on rising edge of clock only.
- Reset is synchronous: while reset==0 at an edge, every register clears. This covers synchronizer flops, counters, all outputs, and the previous-sample register.
- Output values in reset: btn_level=0, btn_pulse=0, btn_sticky=0, press_count=0, sw_stable=0, sw_changed=0.
- Synchronizer: two flops per bit (17 bits total); btn_s and sw_s are the second-stage outputs. A raw change reaches btn_s/sw_s two edges later.
- Button debounce (counter bcnt):
  - If btn_s == btn_level, bcnt <= 0.
  - Else if bcnt == DEBOUNCE_CYCLES-1, btn_level <= btn_s and bcnt <= 0.
  - Else bcnt <= bcnt+1.
  - Net effect: btn_level follows a change DEBOUNCE_CYCLES edges after btn_s first differs. Total raw-to-level latency is 2+DEBOUNCE_CYCLES edges.
  - Any glitch on btn_s shorter than DEBOUNCE_CYCLES cycles resets bcnt and is discarded.
- btn_pulse: registered. It is 1 for exactly the cycle following the edge where btn_level goes 0->1, else 0. No pulse on 1->0.
- btn_sticky:
  - Set by btn_pulse; cleared by clr_sticky==1.
  - If set and clear coincide (btn_pulse==1 and clr_sticky==1 in the same cycle), set wins, so no press is lost.
- press_count: increments by 1 on each edge where btn_pulse==1; 255 -> 0 wrap. Not affected by clr_sticky.
- Switch debounce (one shared counter scnt, register sw_prev <= sw_s every cycle):
  - If sw_s != sw_prev (any bit moving), scnt <= 0.
  - Else if sw_s == sw_stable, scnt <= 0.
  - Else if scnt == DEBOUNCE_CYCLES-1, sw_stable <= sw_s, scnt <= 0, and sw_changed is 1 in the following cycle.
  - Else scnt <= scnt+1.
  - Net effect: the vector is accepted atomically only after all 16 bits have held one value for DEBOUNCE_CYCLES consecutive cycles.
- sw_changed: single-cycle strobe, registered, coincident with the first cycle in which the new sw_stable is visible.
- Reset mid-debounce: in-progress counts are discarded. If an input is still held after reset release, it requires the full 2+DEBOUNCE_CYCLES latency again. A held button after reset therefore produces exactly one btn_pulse and press_count=1.
- Counters never exceed DEBOUNCE_CYCLES-1; no overflow path.

Test Plan:
(All with DEBOUNCE_CYCLES=4.)
1. reset=0 for 3 edges with btn_raw=1, sw_raw=16'hFFFF -> all outputs 0 throughout. Release reset holding inputs:
   - btn_level=1 visible 6 edges later, btn_pulse high exactly 1 cycle, press_count=1.
   - sw_stable=16'hFFFF with a single sw_changed pulse.
2. Button glitch: btn_raw high for 3 cycles then low -> btn_level stays 0, no btn_pulse, press_count unchanged.
3. Three clean presses (high 10, low 10 cycles each) -> three single-cycle btn_pulse, press_count=3, no pulse on releases. Then assert clr_sticky one cycle -> btn_sticky=0.
4. Assert clr_sticky in the exact cycle btn_pulse=1 -> btn_sticky remains 1. Preload 255 presses then one more -> press_count=0.
5. sw_raw toggles bit 3 every 2 cycles for 20 cycles, then settles at 16'h0008 -> no sw_changed during toggling. sw_stable=16'h0008 with one sw_changed exactly 4+2 edges after the last change plus the sw_prev stage.
6. Drive reset=0 one cycle in the middle of a button debounce (bcnt=2) -> outputs 0 next cycle. With btn_raw still high, btn_level rises 6 edges after reset release.
